// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU with iterative multiply/divide:
// op-code encodings, controller state encodings and op classification.
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_NOR   = 5'd6,
        OP_XOR   = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_SLT   = 5'd11,
        OP_SLTU  = 5'd12,
        OP_LUI   = 5'd13,
        OP_MULT  = 5'd14,
        OP_MULTU = 5'd15,
        OP_DIV   = 5'd16,
        OP_DIVU  = 5'd17
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Ops that go through the iterative datapath instead of the one-cycle path
    function automatic logic is_muldiv(input op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide datapath. Works on operand magnitudes, one bit
// per cycle, and presents the sign-corrected HI/LO alongside the final step
// so the controller can register them on the same edge.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    logic [WIDTH-1:0]   part_hi;
    logic [WIDTH-1:0]   part_lo;
    logic [WIDTH-1:0]   opnd_b;
    logic [WIDTH-1:0]   a_keep;
    logic [SHW-1:0]     count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   trial;
    logic               fits;
    logic [WIDTH-1:0]   next_hi;
    logic [WIDTH-1:0]   next_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Operand magnitudes and sign flags taken from the start-cycle inputs
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        sign_a    = op_signed && a[WIDTH-1];
        sign_b    = op_signed && b[WIDTH-1];
        mag_a     = sign_a ? (~a + 1'b1) : a;
        mag_b     = sign_b ? (~b + 1'b1) : b;
    end

    // One shift-add (multiply) or restoring-subtract (divide) iteration, plus final sign fixup
    always_comb begin
        msum     = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
        shifted  = {part_hi, part_lo[WIDTH-1]};
        fits     = shifted >= {1'b0, opnd_b};
        trial    = shifted[WIDTH-1:0] - opnd_b;
        next_hi  = msum[WIDTH:1];
        next_lo  = {msum[0], part_lo[WIDTH-1:1]};
        if (is_div) begin
            next_hi = fits ? trial : shifted[WIDTH-1:0];
            next_lo = {part_lo[WIDTH-2:0], fits};
        end
        prod_fix = neg_q ? (~{next_hi, next_lo} + 1'b1) : {next_hi, next_lo};
        q_fix    = neg_q ? (~next_lo + 1'b1) : next_lo;
        r_fix    = neg_r ? (~next_hi + 1'b1) : next_hi;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            res_hi = div_zero ? a_keep : r_fix;
            res_lo = div_zero ? {WIDTH{1'b1}} : q_fix;
        end
        last = step && (count == LAST_STEP);
    end

    // Operand/partial registers: loaded on an accepted start, advanced once per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_hi  <= '0;
            part_lo  <= '0;
            opnd_b   <= '0;
            a_keep   <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            part_hi  <= '0;
            part_lo  <= mag_a;
            opnd_b   <= mag_b;
            a_keep   <= a;
            count    <= '0;
            is_div   <= (op == OP_DIV) || (op == OP_DIVU);
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= (b == '0);
        end else if (step) begin
            part_hi  <= next_hi;
            part_lo  <= next_lo;
            count    <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Multicycle-core ALU: registered single-cycle ops plus an iterative
// multiply/divide unit, sequenced by a start/busy/done handshake.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int OPW   = OP_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rlt,
    output logic             zero,
    output logic             over,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state_q;
    state_e           state_d;
    op_e              op_dec;
    logic             accept;
    logic             md_load;
    logic             md_step;
    logic             md_last;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_rlt;
    logic             alu_over;

    assign op_dec  = op_e'(op);
    assign accept  = (state_q == ST_IDLE) && start;
    assign md_load = accept && is_muldiv(op_dec);
    assign md_step = (state_q == ST_RUN);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_FIN);
    assign sum     = a + b;
    assign diff    = a - b;
    assign shamt   = a[SHW-1:0];

    alu_muldiv_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (md_load),
        .step   (md_step),
        .op     (op_dec),
        .a      (a),
        .b      (b),
        .last   (md_last),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Single-cycle result and signed-overflow flag; undefined ops yield zero
    always_comb begin
        alu_rlt  = '0;
        alu_over = 1'b0;
        case (op_dec)
            OP_ADD: begin
                alu_rlt  = sum;
                alu_over = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_rlt = sum;
            OP_SUB: begin
                alu_rlt  = diff;
                alu_over = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: alu_rlt = diff;
            OP_AND:  alu_rlt = a & b;
            OP_OR:   alu_rlt = a | b;
            OP_NOR:  alu_rlt = ~(a | b);
            OP_XOR:  alu_rlt = a ^ b;
            OP_SLL:  alu_rlt = b << shamt;
            OP_SRL:  alu_rlt = b >> shamt;
            OP_SRA:  alu_rlt = $signed(b) >>> shamt;
            OP_SLT:  alu_rlt = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_rlt = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:  alu_rlt = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: ;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: single-cycle ops go straight to FIN, mul/div iterate in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = is_muldiv(op_dec) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (md_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers: loaded when a single-cycle op is accepted or the last iteration completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rlt  <= '0;
            zero <= 1'b0;
            over <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else if (accept && !is_muldiv(op_dec)) begin
            rlt  <= alu_rlt;
            zero <= (alu_rlt == '0);
            over <= alu_over;
        end else if (md_last) begin
            rlt  <= md_lo;
            zero <= (md_lo == '0);
            over <= 1'b0;
            hi   <= md_hi;
            lo   <= md_lo;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed corner cases followed by random
// operations, all compared against an arithmetic reference model.
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] rlt;
    logic        zero;
    logic        over;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vec_count   = 0;
    int          miscompares = 0;

    logic [31:0] exp_rlt;
    logic        exp_zero;
    logic        exp_over;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    alu_mdu #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .rlt   (rlt),
        .zero  (zero),
        .over  (over),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so a stuck handshake cannot hang the run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_count++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
        end
    endtask

    // Reference model: architectural result of one operation from plain arithmetic
    task automatic modelStep(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      s;
        longint      p;
        logic [63:0] pu;
        int          sx;
        int          sy;
        sx = $signed(x);
        sy = $signed(y);
        exp_over = 1'b0;
        case (o)
            OP_ADD: begin
                s = longint'(sx) + longint'(sy);
                exp_rlt  = x + y;
                exp_over = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_ADDU: exp_rlt = x + y;
            OP_SUB: begin
                s = longint'(sx) - longint'(sy);
                exp_rlt  = x - y;
                exp_over = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUBU: exp_rlt = x - y;
            OP_AND:  exp_rlt = x & y;
            OP_OR:   exp_rlt = x | y;
            OP_NOR:  exp_rlt = ~(x | y);
            OP_XOR:  exp_rlt = x ^ y;
            OP_SLL:  exp_rlt = y << x[4:0];
            OP_SRL:  exp_rlt = y >> x[4:0];
            OP_SRA:  exp_rlt = $signed(y) >>> x[4:0];
            OP_SLT:  exp_rlt = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU: exp_rlt = (x < y) ? 32'd1 : 32'd0;
            OP_LUI:  exp_rlt = y * 32'd65536;
            OP_MULT: begin
                p  = longint'(sx) * longint'(sy);
                pu = p;
                exp_hi = pu[63:32];
                exp_lo = pu[31:0];
                exp_rlt = exp_lo;
            end
            OP_MULTU: begin
                pu = {32'd0, x} * {32'd0, y};
                exp_hi = pu[63:32];
                exp_lo = pu[31:0];
                exp_rlt = exp_lo;
            end
            OP_DIV: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFFFFFF;
                    exp_hi = x;
                end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    exp_lo = 32'h80000000;
                    exp_hi = 32'd0;
                end else begin
                    exp_lo = sx / sy;
                    exp_hi = sx % sy;
                end
                exp_rlt = exp_lo;
            end
            OP_DIVU: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFFFFFF;
                    exp_hi = x;
                end else begin
                    exp_lo = x / y;
                    exp_hi = x % y;
                end
                exp_rlt = exp_lo;
            end
            default: exp_rlt = 32'd0;
        endcase
        exp_zero = (exp_rlt == 32'd0);
    endtask

    // Issue one op and check latency, busy length, results and the single-cycle done pulse.
    // mode 1: stray start during RUN; mode 2: start held into the FIN cycle.
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input int mode);
        int   cyc;
        int   busy_cycles;
        int   exp_lat;
        int   exp_busy;
        logic seen;
        logic md;
        md       = (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
        exp_lat  = md ? 33 : 1;
        exp_busy = md ? 32 : 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        modelStep(o, x, y);
        cyc         = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mode != 2 && cyc == 1) start = 1'b0;
            if (mode == 2 && cyc == 2) start = 1'b0;
            if (mode == 1 && cyc == 5) begin
                start = 1'b1;
                op    = OP_ADD;
            end
            if (mode == 1 && cyc == 6) start = 1'b0;
            if (cyc > 1 || mode != 2) op = 5'($urandom_range(0, 17));
            a = $urandom;
            b = $urandom;
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        checkOutput("done_latency", cyc, exp_lat);
        checkOutput("busy_cycles", busy_cycles, exp_busy);
        checkOutput("rlt", rlt, exp_rlt);
        checkOutput("zero", {31'd0, zero}, {31'd0, exp_zero});
        checkOutput("over", {31'd0, over}, {31'd0, exp_over});
        checkOutput("hi", hi, exp_hi);
        checkOutput("lo", lo, exp_lo);
        @(negedge clk);
        checkOutput("done_pulse_end", {31'd0, done}, 32'd0);
        checkOutput("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_rlt"},  rlt, 32'd0);
        checkOutput({pfx, "_zero"}, {31'd0, zero}, 32'd0);
        checkOutput({pfx, "_over"}, {31'd0, over}, 32'd0);
        checkOutput({pfx, "_hi"},   hi, 32'd0);
        checkOutput({pfx, "_lo"},   lo, 32'd0);
        checkOutput({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({pfx, "_done"}, {31'd0, done}, 32'd0);
        exp_rlt  = 32'd0;
        exp_zero = 1'b0;
        exp_over = 1'b0;
        exp_hi   = 32'd0;
        exp_lo   = 32'd0;
    endtask

    initial begin
        int          dcount;
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 5'd0;
        a     = 32'd0;
        b     = 32'd0;
        #1;
        checkResetState("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'd1, 0);
        checkOutput("add_lit", rlt, 32'h80000000);
        checkOutput("add_over_lit", {31'd0, over}, 32'd1);
        applyStimulus(OP_ADDU, 32'h7FFFFFFF, 32'd1, 0);
        applyStimulus(OP_SUB, 32'd5, 32'd5, 0);
        checkOutput("sub_zero_lit", {31'd0, zero}, 32'd1);
        applyStimulus(OP_SUB, 32'h80000000, 32'd1, 0);
        applyStimulus(OP_SLT, 32'hFFFFFFFF, 32'd1, 0);
        applyStimulus(OP_SLTU, 32'hFFFFFFFF, 32'd1, 0);
        applyStimulus(OP_SRA, 32'd4, 32'h80000010, 0);
        checkOutput("sra_lit", rlt, 32'hF8000001);
        applyStimulus(OP_SLL, 32'd0, 32'h00001234, 0);
        applyStimulus(OP_LUI, 32'd0, 32'hABCD1234, 0);
        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 1);
        checkOutput("mult_hi_lit", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo_lit", lo, 32'hFFFFFFFA);
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
        checkOutput("div_lo_lit", lo, 32'hFFFFFFFD);
        checkOutput("div_hi_lit", hi, 32'hFFFFFFFF);
        applyStimulus(OP_DIVU, 32'd7, 32'd0, 0);
        checkOutput("divu0_lo_lit", lo, 32'hFFFFFFFF);
        checkOutput("divu0_hi_lit", hi, 32'd7);
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        checkOutput("divmin_lo_lit", lo, 32'h80000000);
        checkOutput("divmin_hi_lit", hi, 32'd0);
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        applyStimulus(OP_XOR, 32'h0F0F0F0F, 32'hFFFF0000, 2);
        applyStimulus(5'd25, 32'd3, 32'd4, 0);

        $display("[TB] reset during RUN");
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'h12345678;
        b     = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetState("abort");
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("abort_no_done", dcount, 32'd0);
        applyStimulus(OP_ADD, 32'd100, 32'hFFFFFFF6, 0);

        $display("[TB] random cases");
        for (int i = 0; i < 40; i++) begin
            rop = 5'($urandom_range(0, 19));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin
                    ra = 32'h80000000;
                    rb = 32'hFFFFFFFF;
                end
                2: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            applyStimulus(rop, ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
